riscv_core_div_ctrl: RTL

Execute-stage initiator for the iterative divide unit. Accepts decoded DIV/DIVU/REM/REMU(W) operations from the execute stage, launches the divider, stalls the pipeline while the divide is in flight, and presents the result on a writeback port held until accepted. It handles pipeline flush mid-divide and optionally returns a cached result for a repeated identical divide.

---
 rtl/riscv_core_pkg.sv | 15 +
 rtl/riscv_core_div_reuse.sv | 58 +++++
 rtl/riscv_core_div_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the riscv_core execute-stage divide controller.
package riscv_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } div_ctrl_state_e;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

endpackage

// File: rtl/riscv_core_div_reuse.sv
// One-entry divide result cache with a full-operand hit compare.
// Only instantiated when RISCV_DIV_REUSE_EN is defined.
module riscv_core_div_reuse #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_src_a,
  input  logic [XLEN-1:0] wr_src_b,
  input  logic [1:0]      wr_control,
  input  logic            wr_isword,
  input  logic [XLEN-1:0] wr_result,
  input  logic [XLEN-1:0] lk_src_a,
  input  logic [XLEN-1:0] lk_src_b,
  input  logic [1:0]      lk_control,
  input  logic            lk_isword,
  output logic            hit,
  output logic [XLEN-1:0] hit_result
);

  logic            valid_r;
  logic [XLEN-1:0] src_a_r;
  logic [XLEN-1:0] src_b_r;
  logic [1:0]      control_r;
  logic            isword_r;
  logic [XLEN-1:0] result_r;
  logic            match_s;

  // Cache entry: only a completed divide refreshes it, only reset invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      src_a_r   <= {XLEN{1'b0}};
      src_b_r   <= {XLEN{1'b0}};
      control_r <= 2'b00;
      isword_r  <= 1'b0;
      result_r  <= {XLEN{1'b0}};
    end else if (wr_en) begin
      valid_r   <= 1'b1;
      src_a_r   <= wr_src_a;
      src_b_r   <= wr_src_b;
      control_r <= wr_control;
      isword_r  <= wr_isword;
      result_r  <= wr_result;
    end
  end

  // Hit requires every operand field to match the stored entry.
  always_comb begin
    match_s = (lk_src_a == src_a_r) && (lk_src_b == src_b_r) &&
              (lk_control == control_r) && (lk_isword == isword_r);
  end

  assign hit        = valid_r & match_s;
  assign hit_result = result_r;

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// Execute-stage initiator for the iterative divider: launch, stall, writeback hold, flush.
// Optional result reuse cache enabled by defining RISCV_DIV_REUSE_EN.
module riscv_core_div_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_div_ctrl_clk,
  input  logic            i_div_ctrl_rstn,
  input  logic            i_div_ctrl_valid,
  input  logic [XLEN-1:0] i_div_ctrl_srcA,
  input  logic [XLEN-1:0] i_div_ctrl_srcB,
  input  logic [1:0]      i_div_ctrl_control,
  input  logic            i_div_ctrl_isword,
  input  logic [4:0]      i_div_ctrl_rd,
  input  logic            i_div_ctrl_flush,
  input  logic            i_div_ctrl_wb_ready,
  input  logic            i_div_ctrl_done,
  input  logic [XLEN-1:0] i_div_ctrl_result,
  output logic            o_div_ctrl_en,
  output logic [XLEN-1:0] o_div_ctrl_srcA,
  output logic [XLEN-1:0] o_div_ctrl_srcB,
  output logic [1:0]      o_div_ctrl_control,
  output logic            o_div_ctrl_isword,
  output logic            o_div_ctrl_stall,
  output logic            o_div_ctrl_wb_valid,
  output logic [4:0]      o_div_ctrl_wb_rd,
  output logic [XLEN-1:0] o_div_ctrl_wb_data
);

  div_ctrl_state_e state_r;
  logic            en_r;
  logic [XLEN-1:0] src_a_r;
  logic [XLEN-1:0] src_b_r;
  logic [1:0]      control_r;
  logic            isword_r;
  logic            wb_valid_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] wb_data_r;
  logic            req_s;
  logic            stall_s;
  logic            hit_s;
  logic [XLEN-1:0] hit_data_s;

  // A request with rd=x0 is architecturally a no-op and never launches.
  always_comb begin
    req_s = i_div_ctrl_valid & (i_div_ctrl_rd != 5'd0) & ~i_div_ctrl_flush;
  end

`ifdef RISCV_DIV_REUSE_EN
  logic cache_wr_s;

  // Refresh the cache only on a done that is actually accepted.
  always_comb begin
    cache_wr_s = (state_r == BUSY) & i_div_ctrl_done & ~i_div_ctrl_flush;
  end

  riscv_core_div_reuse #(
    .XLEN (XLEN)
  ) u_reuse (
    .clk        (i_div_ctrl_clk),
    .rst_n      (i_div_ctrl_rstn),
    .wr_en      (cache_wr_s),
    .wr_src_a   (src_a_r),
    .wr_src_b   (src_b_r),
    .wr_control (control_r),
    .wr_isword  (isword_r),
    .wr_result  (i_div_ctrl_result),
    .lk_src_a   (i_div_ctrl_srcA),
    .lk_src_b   (i_div_ctrl_srcB),
    .lk_control (i_div_ctrl_control),
    .lk_isword  (i_div_ctrl_isword),
    .hit        (hit_s),
    .hit_result (hit_data_s)
  );
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = {XLEN{1'b0}};
`endif

  // Stall decode; held low during reset so every output reads zero.
  always_comb begin
    stall_s = 1'b0;
    if (!i_div_ctrl_rstn || i_div_ctrl_flush) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_s = req_s;
        BUSY:    stall_s = 1'b1;
        RESULT:  stall_s = ~i_div_ctrl_wb_ready;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Control FSM; flush outranks done and wb_ready.
  always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
    if (!i_div_ctrl_rstn) begin
      state_r    <= IDLE;
      en_r       <= 1'b0;
      src_a_r    <= {XLEN{1'b0}};
      src_b_r    <= {XLEN{1'b0}};
      control_r  <= 2'b00;
      isword_r   <= 1'b0;
      wb_valid_r <= 1'b0;
      rd_r       <= 5'd0;
      wb_data_r  <= {XLEN{1'b0}};
    end else if (i_div_ctrl_flush) begin
      state_r    <= IDLE;
      en_r       <= 1'b0;
      wb_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            rd_r <= i_div_ctrl_rd;
            if (hit_s) begin
              state_r    <= RESULT;
              wb_valid_r <= 1'b1;
              wb_data_r  <= hit_data_s;
            end else begin
              state_r   <= BUSY;
              en_r      <= 1'b1;
              src_a_r   <= i_div_ctrl_srcA;
              src_b_r   <= i_div_ctrl_srcB;
              control_r <= i_div_ctrl_control;
              isword_r  <= i_div_ctrl_isword;
            end
          end
        end
        BUSY: begin
          if (i_div_ctrl_done) begin
            state_r    <= RESULT;
            en_r       <= 1'b0;
            wb_valid_r <= 1'b1;
            wb_data_r  <= i_div_ctrl_result;
          end
        end
        RESULT: begin
          if (i_div_ctrl_wb_ready) begin
            state_r    <= IDLE;
            wb_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          en_r       <= 1'b0;
          wb_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_div_ctrl_en       = en_r;
  assign o_div_ctrl_srcA     = src_a_r;
  assign o_div_ctrl_srcB     = src_b_r;
  assign o_div_ctrl_control  = control_r;
  assign o_div_ctrl_isword   = isword_r;
  assign o_div_ctrl_stall    = stall_s;
  assign o_div_ctrl_wb_valid = wb_valid_r;
  assign o_div_ctrl_wb_rd    = rd_r;
  assign o_div_ctrl_wb_data  = wb_data_r;

endmodule
